// File: rtl/zuss_pkg.sv
// Shared ZUSS core definitions: default datapath width and architectural register indexing.
package zuss_pkg;
  localparam int XLEN_DEF = 32;
  localparam int RV32_AW  = 5;

  typedef logic [RV32_AW-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = '0;
endpackage

// File: rtl/zuss_reg_file_mp_if.sv
// Decode/writeback side bundle of the multi-port register file: read ports, write ports, reserve and flush.
interface zuss_reg_file_mp_if
  import zuss_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2
);
  localparam int AW = $clog2(NREG);

  logic [NRD-1:0][AW-1:0]   r_addr;
  logic [NRD-1:0][XLEN-1:0] r_data;
  logic [NRD-1:0]           r_busy;
  logic [NWR-1:0]           w_en;
  logic [NWR-1:0][AW-1:0]   w_addr;
  logic [NWR-1:0][XLEN-1:0] w_data;
  logic                     rsv_en;
  logic [AW-1:0]            rsv_addr;
  logic                     flush;

  modport master (
    output r_addr, w_en, w_addr, w_data, rsv_en, rsv_addr, flush,
    input  r_data, r_busy
  );

  modport slave (
    input  r_addr, w_en, w_addr, w_data, rsv_en, rsv_addr, flush,
    output r_data, r_busy
  );
endinterface

// File: rtl/zuss_rf_scoreboard.sv
// Per-register busy bits: writes clear, a reserve re-sets (newer producer), flush clears everything.
module zuss_rf_scoreboard #(
  parameter int NREG = 32,
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_rsv_en,
  input  logic [AW-1:0]          i_rsv_addr,
  input  logic                   i_flush,
  input  logic [NWR-1:0]         i_wr_en,
  input  logic [NWR-1:0][AW-1:0] i_wr_addr,
  input  logic [NRD-1:0][AW-1:0] i_rd_addr,
  input  logic [NRD-1:0]         i_rd_hit,
  output logic [NRD-1:0]         o_rd_busy
);
  logic [NREG-1:0] r_busy;
  logic [NREG-1:0] w_busy_nxt;

  // Order encodes priority: flush > reserve > write clear.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int j = 0; j < NWR; j++)
      if (i_wr_en[j]) w_busy_nxt[i_wr_addr[j]] = 1'b0;
    if (i_rsv_en) w_busy_nxt[i_rsv_addr] = 1'b1;
    if (i_flush)  w_busy_nxt = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_busy <= '0;
    else     r_busy <= w_busy_nxt;
  end

  // A same-cycle write to the read address is the pending result arriving now.
  always_comb begin
    for (int i = 0; i < NRD; i++)
      o_rd_busy[i] = r_busy[i_rd_addr[i]] && !i_rd_hit[i];
  end
endmodule

// File: rtl/zuss_reg_file_mp.sv
// Parametrised multi-port integer register file with write-to-read bypass and busy scoreboard.
module zuss_reg_file_mp
  import zuss_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREG     = 32,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int ZERO_REG = 1
) (
  input logic              clk,
  input logic              rst,
  zuss_reg_file_mp_if.slave bus
);
  localparam int AW = $clog2(NREG);

  logic [NREG-1:0][XLEN-1:0] r_mem;
  logic [NWR-1:0]            w_we;
  logic                      w_rsv_en;
  logic [NRD-1:0]            w_hit;

  function automatic logic is_zero(input logic [AW-1:0] a);
    return (ZERO_REG != 0) && (a == AW'(REG_ZERO));
  endfunction

  // Hardwired x0 is handled by dropping its writes and reserves up front,
  // so it never bypasses, never gets stored and never goes busy.
  always_comb begin
    for (int j = 0; j < NWR; j++)
      w_we[j] = bus.w_en[j] && !is_zero(bus.w_addr[j]);
    w_rsv_en = bus.rsv_en && !is_zero(bus.rsv_addr);
  end

  // Ascending port order makes the highest-indexed colliding write win.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem <= '0;
    end else begin
      for (int j = 0; j < NWR; j++)
        if (w_we[j]) r_mem[bus.w_addr[j]] <= bus.w_data[j];
    end
  end

  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      bus.r_data[i] = r_mem[bus.r_addr[i]];
      w_hit[i]      = 1'b0;
      for (int j = 0; j < NWR; j++) begin
        if (w_we[j] && (bus.w_addr[j] == bus.r_addr[i])) begin
          bus.r_data[i] = bus.w_data[j];
          w_hit[i]      = 1'b1;
        end
      end
    end
  end

  zuss_rf_scoreboard #(
    .NREG(NREG),
    .NRD (NRD),
    .NWR (NWR),
    .AW  (AW)
  ) u_sb (
    .clk       (clk),
    .rst       (rst),
    .i_rsv_en  (w_rsv_en),
    .i_rsv_addr(bus.rsv_addr),
    .i_flush   (bus.flush),
    .i_wr_en   (w_we),
    .i_wr_addr (bus.w_addr),
    .i_rd_addr (bus.r_addr),
    .i_rd_hit  (w_hit),
    .o_rd_busy (bus.r_busy)
  );
endmodule

// File: tb/tb_zuss_reg_file_mp.sv
// Bench for zuss_reg_file_mp: directed vector table, hand sequences, random run vs. array model (x0 hardwired and ordinary builds).
module tb_zuss_reg_file_mp;
  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int NWR  = 2;
  localparam int AW   = 5;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  zuss_reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) b  ();
  zuss_reg_file_mp_if #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR)) bz ();

  assign bz.r_addr   = b.r_addr;
  assign bz.w_en     = b.w_en;
  assign bz.w_addr   = b.w_addr;
  assign bz.w_data   = b.w_data;
  assign bz.rsv_en   = b.rsv_en;
  assign bz.rsv_addr = b.rsv_addr;
  assign bz.flush    = b.flush;

  zuss_reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .bus(b.slave));
  zuss_reg_file_mp #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD), .NWR(NWR), .ZERO_REG(0)) dut_z (
    .clk(clk), .rst(rst), .bus(bz.slave));

  // Model index 0: x0 hardwired build; index 1: x0 ordinary build.
  logic [XLEN-1:0] mm [2][NREG];
  bit              mb [2][NREG];
  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]      we;
    logic [AW-1:0]   wa0, wa1;
    logic [XLEN-1:0] wd0, wd1;
    logic            rsv;
    logic [AW-1:0]   ra;
    logic            fl;
    logic [AW-1:0]   rd0, rd1;
    logic [XLEN-1:0] ed0, ed1;
    logic            eb0, eb1;
  } vec_t;

  vec_t tbl [21];

  function automatic vec_t mk(logic [1:0] we, int wa0, logic [XLEN-1:0] wd0, int wa1, logic [XLEN-1:0] wd1,
                              logic rsv, int ra, logic fl, int rd0, int rd1,
                              logic [XLEN-1:0] ed0, logic eb0, logic [XLEN-1:0] ed1, logic eb1);
    vec_t v;
    v.we = we; v.wa0 = AW'(wa0); v.wd0 = wd0; v.wa1 = AW'(wa1); v.wd1 = wd1;
    v.rsv = rsv; v.ra = AW'(ra); v.fl = fl; v.rd0 = AW'(rd0); v.rd1 = AW'(rd1);
    v.ed0 = ed0; v.eb0 = eb0; v.ed1 = ed1; v.eb1 = eb1;
    return v;
  endfunction

  function automatic bit zr(int m, logic [AW-1:0] a);
    return (m == 0) && (a == '0);
  endfunction

  function automatic logic [XLEN-1:0] exp_d(int m, logic [AW-1:0] a);
    logic [XLEN-1:0] d;
    if (zr(m, a)) return '0;
    d = mm[m][a];
    for (int j = 0; j < NWR; j++)
      if (b.w_en[j] && b.w_addr[j] == a) d = b.w_data[j];
    return d;
  endfunction

  function automatic logic exp_b(int m, logic [AW-1:0] a);
    if (zr(m, a)) return 1'b0;
    for (int j = 0; j < NWR; j++)
      if (b.w_en[j] && b.w_addr[j] == a) return 1'b0;
    return mb[m][a];
  endfunction

  task automatic chk(string nm, logic [XLEN-1:0] act, logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++)
      for (int a = 0; a < NREG; a++) begin
        mm[m][a] = '0;
        mb[m][a] = 1'b0;
      end
  endtask

  // State change at a rising edge, from the inputs held just before it.
  task automatic model_edge();
    if (rst) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      for (int j = 0; j < NWR; j++)
        if (b.w_en[j] && !zr(m, b.w_addr[j])) begin
          mm[m][b.w_addr[j]] = b.w_data[j];
          mb[m][b.w_addr[j]] = 1'b0;
        end
      if (b.rsv_en && !zr(m, b.rsv_addr)) mb[m][b.rsv_addr] = 1'b1;
      if (b.flush)
        for (int a = 0; a < NREG; a++) mb[m][a] = 1'b0;
    end
  endtask

  task automatic check_model(string tag);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < NRD; i++) begin
        chk($sformatf("%s_m%0d_data%0d@x%0d", tag, m, i, b.r_addr[i]),
            (m == 0) ? b.r_data[i] : bz.r_data[i], exp_d(m, b.r_addr[i]));
        chk($sformatf("%s_m%0d_busy%0d@x%0d", tag, m, i, b.r_addr[i]),
            XLEN'((m == 0) ? b.r_busy[i] : bz.r_busy[i]), XLEN'(exp_b(m, b.r_addr[i])));
      end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    b.w_en = '0; b.w_addr = '0; b.w_data = '0;
    b.rsv_en = 1'b0; b.rsv_addr = '0; b.flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    b.r_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    for (int a = 0; a < NREG; a++) begin
      b.r_addr[0] = AW'(a);
      b.r_addr[1] = AW'(NREG - 1 - a);
      #1;
      chk($sformatf("rst_d0_x%0d", a), b.r_data[0], '0);
      chk($sformatf("rst_b1_x%0d", a), XLEN'(b.r_busy[1]), '0);
      check_model("rst");
    end
    @(posedge clk);
    #1;
    rst = 1'b0;

    tbl[0]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 6, 0, 0, 0, 0);
    tbl[1]  = mk(2'b11, 5, 32'h1234_5678, 6, 32'hDEAD_BEEF, 0, 0, 0, 5, 6, 32'h1234_5678, 0, 32'hDEAD_BEEF, 0);
    tbl[2]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 5, 6, 32'h1234_5678, 0, 32'hDEAD_BEEF, 0);
    tbl[3]  = mk(2'b11, 7, 32'h1, 7, 32'h2, 0, 0, 0, 7, 5, 32'h2, 0, 32'h1234_5678, 0);
    tbl[4]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 7, 7, 32'h2, 0, 32'h2, 0);
    tbl[5]  = mk(2'b01, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 7, 0, 0, 32'h2, 0);
    tbl[6]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(2'b00, 0, 0, 0, 0, 1, 9, 0, 9, 9, 0, 0, 0, 0);
    tbl[8]  = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 9, 0, 1, 0, 1);
    tbl[9]  = mk(2'b01, 9, 32'h55, 0, 0, 0, 0, 0, 9, 9, 32'h55, 0, 32'h55, 0);
    tbl[10] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h55, 0, 32'h55, 0);
    tbl[11] = mk(2'b10, 0, 0, 9, 32'h66, 1, 9, 0, 9, 9, 32'h66, 0, 32'h66, 0);
    tbl[12] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 9, 9, 32'h66, 1, 32'h66, 1);
    tbl[13] = mk(2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    tbl[14] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 9, 0, 0, 32'h66, 1);
    tbl[15] = mk(2'b00, 0, 0, 0, 0, 1, 3, 0, 3, 4, 0, 0, 0, 0);
    tbl[16] = mk(2'b00, 0, 0, 0, 0, 1, 4, 0, 3, 4, 0, 1, 0, 0);
    tbl[17] = mk(2'b00, 0, 0, 0, 0, 1, 10, 0, 3, 4, 0, 1, 0, 1);
    tbl[18] = mk(2'b00, 0, 0, 0, 0, 1, 11, 1, 10, 11, 0, 1, 0, 0);
    tbl[19] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 3, 10, 0, 0, 0, 0);
    tbl[20] = mk(2'b00, 0, 0, 0, 0, 0, 0, 0, 4, 11, 0, 0, 0, 0);

    foreach (tbl[k]) begin
      b.w_en = tbl[k].we;
      b.w_addr[0] = tbl[k].wa0; b.w_data[0] = tbl[k].wd0;
      b.w_addr[1] = tbl[k].wa1; b.w_data[1] = tbl[k].wd1;
      b.rsv_en = tbl[k].rsv; b.rsv_addr = tbl[k].ra; b.flush = tbl[k].fl;
      b.r_addr[0] = tbl[k].rd0; b.r_addr[1] = tbl[k].rd1;
      #1;
      chk($sformatf("vec%0d_d0", k), b.r_data[0], tbl[k].ed0);
      chk($sformatf("vec%0d_d1", k), b.r_data[1], tbl[k].ed1);
      chk($sformatf("vec%0d_b0", k), XLEN'(b.r_busy[0]), XLEN'(tbl[k].eb0));
      chk($sformatf("vec%0d_b1", k), XLEN'(b.r_busy[1]), XLEN'(tbl[k].eb1));
      check_model($sformatf("vec%0d", k));
      tick();
    end

    // x0 is an ordinary register in the second build and kept the all-ones write.
    idle();
    b.r_addr[0] = '0;
    b.r_addr[1] = '0;
    #1;
    chk("x0_plain_build", bz.r_data[0], 32'hFFFF_FFFF);
    chk("x0_hardwired_build", b.r_data[0], '0);

    // Asynchronous reset between edges with x12 written and busy.
    b.w_en = 2'b01; b.w_addr[0] = AW'(12); b.w_data[0] = 32'hA5A5_A5A5;
    b.rsv_en = 1'b1; b.rsv_addr = AW'(12);
    tick();
    idle();
    b.r_addr[0] = AW'(12);
    b.r_addr[1] = AW'(12);
    #1;
    chk("x12_before_rst_d", b.r_data[0], 32'hA5A5_A5A5);
    chk("x12_before_rst_b", XLEN'(b.r_busy[1]), 1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("x12_async_rst_d", b.r_data[0], '0);
    chk("x12_async_rst_b", XLEN'(b.r_busy[1]), '0);
    check_model("async_rst");
    b.w_en = 2'b01; b.w_addr[0] = AW'(13); b.w_data[0] = 32'h77;
    b.rsv_en = 1'b1; b.rsv_addr = AW'(13);
    b.r_addr[1] = AW'(13);
    #1;
    chk("rst_bypass_d", b.r_data[1], 32'h77);
    tick();
    idle();
    #1;
    chk("rst_edge_no_write", b.r_data[1], '0);
    chk("rst_edge_no_rsv", XLEN'(b.r_busy[1]), '0);
    rst = 1'b0;
    b.w_en = 2'b10; b.w_addr[1] = AW'(13); b.w_data[1] = 32'h77;
    tick();
    idle();
    #1;
    chk("post_rst_write", b.r_data[1], 32'h77);

    // Randomised run against the array model; narrow address range forces collisions.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 99) < 3);
      b.w_en = NWR'($urandom);
      for (int j = 0; j < NWR; j++) begin
        b.w_addr[j] = AW'($urandom_range(0, 15));
        b.w_data[j] = $urandom;
      end
      b.rsv_en = $urandom_range(0, 1) == 1;
      b.rsv_addr = AW'($urandom_range(0, 15));
      b.flush = ($urandom_range(0, 99) < 5);
      for (int i = 0; i < NRD; i++) b.r_addr[i] = AW'($urandom_range(0, 15));
      if (rst) model_reset();
      #1;
      check_model($sformatf("rnd%0d", n));
      tick();
    end
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
